// File: rtl/eth_rx_frame_parser_pkg.sv
// Shared Ethernet receive/transmit constants and helpers.
//   - header/FCS geometry, CRC-32 polynomial and good-frame residue
//   - crc32_byte(): one reflected CRC-32 byte step (also used by the TX path)
//   - mac_byte(): big-endian byte select out of a 48-bit MAC address
//   - rx_state_e: receive frame parser states
package eth_rx_frame_parser_pkg;

  localparam int          ETH_MAC_LEN     = 6;
  localparam int          ETH_HDR_LEN     = 14;
  localparam int          ETH_FCS_LEN     = 4;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [47:0] ETH_BROADCAST   = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_PAYLOAD,
    ST_FIN,      // last byte arrived together with done_in; verdict goes out one clk later
    ST_DROP
  } rx_state_e;

  // Reflected CRC-32, LSB first, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Byte idx (0 = first on the wire = most significant) of a MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac << {idx, 3'b000};
    return sh[47:40];
  endfunction

endpackage

// File: rtl/eth_rx_frame_parser_fcs_checker.sv
// Running CRC-32 over every received byte of a frame (FCS included).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : reload the CRC register with all-ones (takes priority over inclk)
//   inclk, in  : byte strobe and byte
//   crc_ok     : CRC register currently equals the good-frame residue
module eth_rx_frame_parser_fcs_checker
  import eth_rx_frame_parser_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inclk,
  input  logic [7:0] in,
  output logic       crc_ok
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (inclk) begin
      crc_d = crc32_byte(crc_q, in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_ok = (crc_q == ETH_CRC_RESIDUE);

endmodule

// File: rtl/eth_rx_frame_parser.sv
// Receive frame parser: filters on destination MAC and EtherType, strips
// the 14-byte header and 4-byte FCS, forwards payload bytes and reports a
// per-frame verdict.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   inclk, in    : received byte strobe and byte (at most one per 4 clk)
//   done_in      : end-of-frame strobe
//   out, outclk  : payload byte and its strobe
//   done_out     : verdict strobe for the frame just forwarded
//   frame_ok     : FCS good and length in range (valid with done_out)
//   payload_len  : payload bytes forwarded (valid with done_out)
//   src_mac      : source MAC of the last good frame
//   busy         : a frame is in progress
module eth_rx_frame_parser
  import eth_rx_frame_parser_pkg::*;
#(
  parameter logic [47:0] MY_MAC        = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int          MAX_FRAME_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inclk,
  input  logic [7:0]  in,
  input  logic        done_in,
  output logic [7:0]  out,
  output logic        outclk,
  output logic        done_out,
  output logic        frame_ok,
  output logic [10:0] payload_len,
  output logic [47:0] src_mac,
  output logic        busy
);

  localparam logic [10:0] DST_LAST  = 11'(ETH_MAC_LEN - 1);
  localparam logic [10:0] SRC_LAST  = 11'(2 * ETH_MAC_LEN - 1);
  localparam logic [10:0] TYPE_LAST = 11'(ETH_HDR_LEN - 1);
  localparam logic [10:0] MIN_LEN   = 11'(ETH_HDR_LEN + ETH_FCS_LEN);
  localparam logic [10:0] MAX_LEN   = 11'(MAX_FRAME_LEN);

  rx_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;          // bytes of the current frame received so far
  logic        ucast_q, ucast_d;      // destination still matches MY_MAC
  logic        bcast_q, bcast_d;      // destination still matches broadcast
  logic [47:0] src_sh_q, src_sh_d;    // source MAC shadow, committed on a good verdict
  logic [7:0]  type_q, type_d;        // first EtherType byte
  logic [7:0]  out_q, out_d;
  logic        outclk_q, outclk_d;
  logic        done_out_q, done_out_d;
  logic        frame_ok_q, frame_ok_d;
  logic [10:0] payload_len_q, payload_len_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic        busy_q, busy_d;

  logic [7:0]  dly_q [4];             // [0] newest payload byte, [3] oldest
  logic        dly_shift;
  logic        go_idle;

  logic        crc_ok;
  logic        verdict_ok;
  logic [10:0] emitted_len;

  eth_rx_frame_parser_fcs_checker u_fcs (
    .clk    (clk),
    .reset  (reset),
    .clear  (go_idle),
    .inclk  (inclk),
    .in     (in),
    .crc_ok (crc_ok)
  );

  // Once the delay line is full every new byte pushes one out, so the number
  // forwarded is simply the byte count minus header and FCS.
  assign emitted_len = (cnt_q >= MIN_LEN) ? (cnt_q - MIN_LEN) : 11'd0;
  assign verdict_ok  = crc_ok && (cnt_q >= MIN_LEN) && (cnt_q <= MAX_LEN);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ucast_d       = ucast_q;
    bcast_d       = bcast_q;
    src_sh_d      = src_sh_q;
    type_d        = type_q;
    out_d         = out_q;
    outclk_d      = 1'b0;
    done_out_d    = 1'b0;
    frame_ok_d    = frame_ok_q;
    payload_len_d = payload_len_q;
    src_mac_d     = src_mac_q;
    dly_shift     = 1'b0;
    go_idle       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // done_in without a byte is ignored here
        if (inclk) begin
          ucast_d = (in == mac_byte(MY_MAC, 3'd0));
          bcast_d = (in == mac_byte(ETH_BROADCAST, 3'd0));
          cnt_d   = 11'd1;
          state_d = ST_DST;
          if (done_in) go_idle = 1'b1;
        end
      end

      ST_DST: begin
        if (inclk) begin
          ucast_d = ucast_q && (in == mac_byte(MY_MAC, cnt_q[2:0]));
          bcast_d = bcast_q && (in == mac_byte(ETH_BROADCAST, cnt_q[2:0]));
          cnt_d   = cnt_q + 11'd1;
          if (cnt_q == DST_LAST) begin
            state_d = (ucast_d || bcast_d) ? ST_SRC : ST_DROP;
          end
        end
        if (done_in) go_idle = 1'b1;
      end

      ST_SRC: begin
        if (inclk) begin
          src_sh_d = {src_sh_q[39:0], in};
          cnt_d    = cnt_q + 11'd1;
          if (cnt_q == SRC_LAST) state_d = ST_TYPE;
        end
        if (done_in) go_idle = 1'b1;
      end

      ST_TYPE: begin
        if (inclk) begin
          type_d = in;
          cnt_d  = cnt_q + 11'd1;
          if (cnt_q == TYPE_LAST) begin
            state_d = ({type_q, in} == ETHERTYPE) ? ST_PAYLOAD : ST_DROP;
          end
        end
        if (done_in) go_idle = 1'b1;
      end

      ST_PAYLOAD: begin
        if (inclk) begin
          if (cnt_q == MAX_LEN) begin
            // This byte would make the frame too long: fail it now, forward nothing more.
            done_out_d    = 1'b1;
            frame_ok_d    = 1'b0;
            payload_len_d = emitted_len;
            state_d       = ST_DROP;
            if (done_in) go_idle = 1'b1;
          end else begin
            cnt_d     = cnt_q + 11'd1;
            dly_shift = 1'b1;
            if (cnt_q >= MIN_LEN) begin
              out_d    = dly_q[3];
              outclk_d = 1'b1;
            end
            // Verdict waits one clk so it cannot collide with the outclk above
            // and so the CRC includes this byte.
            if (done_in) state_d = ST_FIN;
          end
        end else if (done_in) begin
          done_out_d    = 1'b1;
          frame_ok_d    = verdict_ok;
          payload_len_d = emitted_len;
          if (verdict_ok) src_mac_d = src_sh_q;
          go_idle       = 1'b1;
        end
      end

      ST_FIN: begin
        done_out_d    = 1'b1;
        frame_ok_d    = verdict_ok;
        payload_len_d = emitted_len;
        if (verdict_ok) src_mac_d = src_sh_q;
        go_idle       = 1'b1;
      end

      ST_DROP: begin
        if (done_in) go_idle = 1'b1;
      end

      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d = ST_IDLE;
      cnt_d   = 11'd0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 11'd0;
      ucast_q       <= 1'b0;
      bcast_q       <= 1'b0;
      src_sh_q      <= 48'd0;
      type_q        <= 8'd0;
      out_q         <= 8'd0;
      outclk_q      <= 1'b0;
      done_out_q    <= 1'b0;
      frame_ok_q    <= 1'b0;
      payload_len_q <= 11'd0;
      src_mac_q     <= 48'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ucast_q       <= ucast_d;
      bcast_q       <= bcast_d;
      src_sh_q      <= src_sh_d;
      type_q        <= type_d;
      out_q         <= out_d;
      outclk_q      <= outclk_d;
      done_out_q    <= done_out_d;
      frame_ok_q    <= frame_ok_d;
      payload_len_q <= payload_len_d;
      src_mac_q     <= src_mac_d;
      busy_q        <= busy_d;
    end
  end

  // 4-byte delay line holding back the trailing FCS.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dly
    always_ff @(posedge clk) begin
      if (reset || go_idle) begin
        dly_q[gi] <= 8'd0;
      end else if (dly_shift) begin
        if (gi == 0) begin
          dly_q[gi] <= in;
        end else begin
          dly_q[gi] <= dly_q[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  end

  assign out         = out_q;
  assign outclk      = outclk_q;
  assign done_out    = done_out_q;
  assign frame_ok    = frame_ok_q;
  assign payload_len = payload_len_q;
  assign src_mac     = src_mac_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Randomized and directed frames against a frame-level reference model.
module tb_eth_rx_frame_parser;

  localparam logic [47:0] MY   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTH  = 48'h02_00_00_00_00_02;
  localparam logic [47:0] SRC1 = 48'hA0_B1_C2_D3_E4_F5;
  localparam logic [47:0] SRC2 = 48'h12_34_56_78_9A_BC;
  localparam int          MAXL = 1518;

  logic        clk = 1'b0;
  logic        reset, inclk, done_in;
  logic [7:0]  in_b;
  logic [7:0]  out_b;
  logic        outclk, done_out, frame_ok, busy;
  logic [10:0] payload_len;
  logic [47:0] src_mac;

  eth_rx_frame_parser dut (
    .clk(clk), .reset(reset), .inclk(inclk), .in(in_b), .done_in(done_in),
    .out(out_b), .outclk(outclk), .done_out(done_out), .frame_ok(frame_ok),
    .payload_len(payload_len), .src_mac(src_mac), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct { bit ok; int len; } verdict_t;

  int          total = 0, bad = 0, cyc = 0;
  logic [7:0]  exp_b[$];
  verdict_t    exp_v[$];
  logic [7:0]  frm[$];
  bit          chk_en = 1'b0;
  int          n_out, n_done, done_cyc, last_byte_cyc, ovf_cyc;
  bit          last_ok;
  int          last_len;
  logic [47:0] mdl_src = 48'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-serial CRC-32 of the first n bytes, returned as the FCS value.
  function automatic logic [31:0] fcs_of(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic make_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                            input int plen, input bit rnd, input bit add_fcs, input bit bad_fcs);
    logic [31:0] f;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(src[8*i +: 8]);
    frm.push_back(typ[15:8]);
    frm.push_back(typ[7:0]);
    for (int i = 0; i < plen; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i));
    if (add_fcs) begin
      f = fcs_of(frm, frm.size());
      for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
      if (bad_fcs) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    end
  endtask

  // Frame-level expectations: which bytes come out, and which verdict.
  task automatic model_frame();
    int          n;
    logic [47:0] dst, src;
    logic [15:0] typ;
    logic [31:0] f;
    bit          ok;
    n = frm.size();
    if (n < 14) return;
    dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    src = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
    typ = {frm[12], frm[13]};
    if (!(dst == MY || dst == BC) || typ != 16'h88B5) return;
    if (n > MAXL) begin
      for (int i = 14; i < MAXL - 4; i++) exp_b.push_back(frm[i]);
      exp_v.push_back('{1'b0, MAXL - 18});
      return;
    end
    for (int i = 14; i <= n - 5; i++) exp_b.push_back(frm[i]);
    ok = 1'b0;
    if (n >= 18) begin
      f  = fcs_of(frm, n - 4);
      ok = (f == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
    end
    exp_v.push_back('{ok, (n >= 18) ? n - 18 : 0});
    if (ok) mdl_src = src;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_done);
    in_b = b; inclk = 1'b1; done_in = with_done;
    @(negedge clk);
    inclk = 1'b0; done_in = 1'b0;
    last_byte_cyc = cyc;
    repeat (3 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_frame(input bit simult);
    if (chk_en) model_frame();
    n_out = 0; n_done = 0;
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i], simult && (i == frm.size() - 1));
      if (i == MAXL) ovf_cyc = last_byte_cyc;
    end
    if (!simult) begin
      done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
    end
    repeat (12) @(negedge clk);
    if (chk_en) begin
      chk("missing_bytes", 64'(exp_b.size()), 64'd0);
      chk("missing_verdict", 64'(exp_v.size()), 64'd0);
      chk("busy_after", 64'(busy), 64'd0);
      chk("src_mac", 64'(src_mac), 64'(mdl_src));
    end
  endtask

  // Single compare process: every outclk / done_out checked against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      if (outclk && done_out) chk("out_done_coincide", 64'd1, 64'd0);
      if (outclk) begin
        n_out++;
        if (exp_b.size() == 0) chk("unexpected_outclk", 64'(out_b), 64'hFFFF);
        else chk("out_byte", 64'(out_b), 64'(exp_b.pop_front()));
      end
      if (done_out) begin
        verdict_t v;
        n_done++;
        last_ok  = frame_ok;
        last_len = int'(payload_len);
        done_cyc = cyc;
        if (exp_v.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          v = exp_v.pop_front();
          chk("frame_ok", 64'(frame_ok), 64'(v.ok));
          chk("payload_len", 64'(payload_len), 64'(v.len));
        end
      end
    end
  end

  initial begin
    logic [7:0] tq[$];
    reset = 1'b1; inclk = 1'b0; done_in = 1'b0; in_b = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({out_b, outclk, done_out, frame_ok, payload_len, busy}), 64'd0);
    chk("reset_src", 64'(src_mac), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    for (int i = 0; i < 9; i++) tq.push_back(8'h31 + 8'(i));
    chk("crc_ref_123456789", 64'(fcs_of(tq, 9)), 64'hCBF43926);

    // Broadcast, good FCS
    make_frame(BC, SRC1, 16'h88B5, 46, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0);
    chk("bc_n_out", 64'(n_out), 64'd46);
    chk("bc_ok", 64'(last_ok), 64'd1);
    chk("bc_len", 64'(last_len), 64'd46);
    chk("bc_src", 64'(src_mac), 64'(SRC1));

    // Same with corrupted FCS
    make_frame(BC, SRC2, 16'h88B5, 46, 1'b0, 1'b1, 1'b1);
    send_frame(1'b0);
    chk("badfcs_n_out", 64'(n_out), 64'd46);
    chk("badfcs_ok", 64'(last_ok), 64'd0);
    chk("badfcs_src", 64'(src_mac), 64'(SRC1));

    // Wrong destination
    make_frame(OTH, SRC2, 16'h88B5, 46, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0);
    chk("dst_n_out", 64'(n_out), 64'd0);
    chk("dst_n_done", 64'(n_done), 64'd0);

    // Wrong EtherType, then a valid unicast frame ending with done_in on the last byte
    make_frame(MY, SRC2, 16'h0800, 46, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0);
    chk("type_n_done", 64'(n_done), 64'd0);
    make_frame(MY, SRC2, 16'h88B5, 50, 1'b1, 1'b1, 1'b0);
    send_frame(1'b1);
    chk("uc_ok", 64'(last_ok), 64'd1);
    chk("uc_n_out", 64'(n_out), 64'd50);

    // Header + 2 bytes, then a 10-byte header-only fragment
    make_frame(MY, SRC1, 16'h88B5, 2, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0);
    chk("short_n_done", 64'(n_done), 64'd1);
    chk("short_ok", 64'(last_ok), 64'd0);
    chk("short_len", 64'(last_len), 64'd0);
    make_frame(MY, SRC1, 16'h88B5, 0, 1'b0, 1'b0, 1'b0);
    while (frm.size() > 10) void'(frm.pop_back());
    send_frame(1'b0);
    chk("frag_n_done", 64'(n_done), 64'd0);

    // Oversize frame: verdict right after byte 1519
    make_frame(MY, SRC1, 16'h88B5, 1582, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0);
    chk("ovf_n_done", 64'(n_done), 64'd1);
    chk("ovf_ok", 64'(last_ok), 64'd0);
    chk("ovf_timing", 64'(done_cyc), 64'(ovf_cyc));

    // Reset in the middle of a payload
    chk_en = 1'b0;
    make_frame(MY, SRC2, 16'h88B5, 60, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) send_byte(frm[i], 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_out", 64'({out_b, outclk, done_out, frame_ok, payload_len, busy}), 64'd0);
    chk("midreset_src", 64'(src_mac), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_b.delete(); exp_v.delete();
    mdl_src = 48'd0; n_done = 0;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("midreset_no_done", 64'(n_done), 64'd0);
    make_frame(BC, SRC2, 16'h88B5, 46, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0);
    chk("post_reset_ok", 64'(last_ok), 64'd1);
    chk("post_reset_src", 64'(src_mac), 64'(SRC2));

    // Randomized frames
    for (int k = 0; k < 12; k++) begin
      logic [47:0] d, s;
      logic [15:0] t;
      int          r;
      r = $urandom_range(0, 9);
      d = (r < 5) ? MY : (r < 8) ? BC : OTH;
      s = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      t = ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h88B5;
      make_frame(d, s, t, $urandom_range(0, 100), 1'b1, 1'b1, ($urandom_range(0, 3) == 0));
      send_frame($urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
